// File: rtl/sdram_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_if_pkg
// Purpose  : Definitions shared by the RAM test initiator and the responders
//            on its 32-bit word request interface: interface widths and the
//            responder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_if_pkg;

  localparam int ADDR_BITS = 23;
  localparam int DATA_BITS = 32;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_READY   = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

endpackage : sdram_if_pkg
`default_nettype wire

// File: rtl/bram_sp.sv
`default_nettype none
// ============================================================================
// Module   : bram_sp
// Purpose  : Single-port block RAM with synchronous write and registered read.
//            A read on the cycle after a write to the same index sees the new
//            data. The read register holds its value when no read is issued.
// Ports    : clk    in   clock
//            rst    in   asynchronous active-high reset (read register only)
//            we     in   write enable
//            re     in   read enable
//            addr   in   ADDR_W  word index
//            wdata  in   DATA_W  write data
//            rdata  out  DATA_W  registered read data
// Revision : 1.0 - initial release
// ============================================================================
module bram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : bram_sp
`default_nettype wire

// File: rtl/sdram_model_resp.sv
`default_nettype none
// ============================================================================
// Module   : sdram_model_resp
// Purpose  : Block-RAM responder standing in for the SDRAM controller on the
//            32-bit word request interface. Accepts a request on any edge
//            with in_valid && !busy, writes immediately, and returns reads in
//            order after a fixed RD_LAT cycles.
// Macro    : SDRAM_MODEL_REFRESH_STALL_EN - when defined, busy is raised for
//            REFRESH_CYCLES cycles after every REFRESH_PERIOD ready cycles to
//            emulate SDRAM refresh. Undefined: busy is high only in INIT.
// Ports    : clk       in   clock, rising edge
//            rst       in   asynchronous active-high reset
//            addr      in   23  word address (upper bits above ADDR_W ignored)
//            rw        in   1 = write, 0 = read
//            data_in   in   32  write data
//            in_valid  in   request strobe
//            busy      out  registered; requests dropped while high
//            data_out  out  32  registered read data
//            out_valid out  registered one-cycle pulse per read
// Revision : 1.0 - initial release
// ============================================================================
module sdram_model_resp
  import sdram_if_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 2,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rw,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 in_valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid
);

  state_e state_q;
  state_e state_d;
  logic   busy_q;
  logic   busy_d;

  logic   accept;
  logic   wr_accept;
  logic   rd_accept;

  logic [RD_LAT-1:0]    vld_q;
  logic [RD_LAT-1:0]    vld_d;
  logic [DATA_BITS-1:0] ram_rdata;

  // busy is a flop, so the initiator may look at it combinationally.
  assign accept    = in_valid && !busy_q;
  assign wr_accept = accept && rw;
  assign rd_accept = accept && !rw;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  bram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_BITS)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .re    (rd_accept),
    .addr  (addr[ADDR_W-1:0]),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  generate
    if (ADDR_W < ADDR_BITS) begin : g_addr_alias
      // Upper address bits alias onto the array and are intentionally dropped.
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_BITS-1:ADDR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM and refresh counter
  // --------------------------------------------------------------------------
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
  localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // One counter serves both phases: ready cycles while READY, stall cycles
  // while REFRESH. It restarts at 0 on every phase change.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = ^{32'(REFRESH_PERIOD), 32'(REFRESH_CYCLES)};
`endif

  always_comb begin
    state_d = state_q;
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
        state_d = ST_READY;
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
        cnt_d   = '0;
`endif
      end
      ST_READY: begin
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
        // A request seen in the terminal cycle is still accepted; busy only
        // rises on the following edge.
        if (cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
          state_d = ST_REFRESH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        state_d = ST_READY;
`endif
      end
      ST_REFRESH: begin
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        state_d = ST_INIT;
`endif
      end
      default: begin
        state_d = ST_INIT;
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
        cnt_d   = '0;
`endif
      end
    endcase
    busy_d = (state_d != ST_READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      busy_q  <= 1'b1;
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy = busy_q;

  // --------------------------------------------------------------------------
  // Read return pipeline
  // --------------------------------------------------------------------------
  // vld_q[0] is set on the accept edge, matching the RAM read register; each
  // further stage adds one cycle. Nothing here looks at busy, so reads already
  // in flight drain through a refresh window.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_accept;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];

  generate
    if (RD_LAT == 1) begin : g_lat_one
      assign data_out = ram_rdata;
    end else begin : g_lat_pipe
      // Data stages shift every cycle; the valid pipe says which word is live.
      logic [DATA_BITS-1:0] dat_q [RD_LAT-1];
      logic [DATA_BITS-1:0] dat_d [RD_LAT-1];

      always_comb begin
        dat_d    = '{default: '0};
        dat_d[0] = ram_rdata;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT - 1; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          dat_q <= dat_d;
        end
      end

      assign data_out = dat_q[RD_LAT-2];
    end
  endgenerate

endmodule : sdram_model_resp
`default_nettype wire

// File: tb/tb_sdram_model_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_model_resp
// Purpose  : Directed self-checking bench for sdram_model_resp with
//            ADDR_W=10, RD_LAT=2, REFRESH_PERIOD=16, REFRESH_CYCLES=4.
//            The refresh scenario is built only with
//            SDRAM_MODEL_REFRESH_STALL_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_model_resp;

  logic        clk;
  logic        rst;
  logic [22:0] addr;
  logic        rw;
  logic [31:0] data_in;
  logic        in_valid;
  logic        busy;
  logic [31:0] data_out;
  logic        out_valid;

  int total;
  int bad;

  sdram_model_resp #(
    .ADDR_W         (10),
    .RD_LAT         (2),
    .REFRESH_PERIOD (16),
    .REFRESH_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rw        (rw),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .busy      (busy),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 64 && busy; i++) tick();
    if (busy) ok = 1'b0;
  endtask

  task automatic wr(input logic [22:0] a, input logic [31:0] d);
    bit ok;
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr_ready: busy stuck high, got %0b required 0", busy);
    end
    in_valid = 1'b1; rw = 1'b1; addr = a; data_in = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the read word and the accept-to-out_valid latency (-1 on timeout).
  task automatic rd(input logic [22:0] a, output logic [31:0] d, output int lat);
    bit ok;
    wait_ready(ok);
    in_valid = 1'b1; rw = 1'b0; addr = a;
    tick();
    in_valid = 1'b0;
    lat = -1;
    d   = '0;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid) begin
        lat = k;
        d   = data_out;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_busy: got %b required 1", busy);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL reset_data_out: got %h required 00000000", data_out);
    end
    rst = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_busy_init: got %b required 1", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy_ready: got %b required 0", busy);
    end
  endtask

  task automatic test_single_rw();
    logic [31:0] d;
    int lat;
    do_reset();
    wr(23'd5, 32'hDEADBEEF);
    rd(23'd5, d, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL single_latency: got %0d required 2", lat);
    end
    total++;
    if (d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_data: got %h required deadbeef", d);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_pulse: got %b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'h11111111 * (i + 1);
      wr(23'(i), exp_d[i]);
    end
    in_valid = 1'b1; rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 23'(i);
      tick();
      total++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_first_early: got %b required 0", out_valid);
        end
      end else if (out_valid !== 1'b1 || data_out !== exp_d[i-1]) begin
        bad++; $display("FAIL b2b_read%0d: got v=%b %h required v=1 %h", i-1, out_valid, data_out, exp_d[i-1]);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || data_out !== exp_d[3]) begin
      bad++; $display("FAIL b2b_read3: got v=%b %h required v=1 %h", out_valid, data_out, exp_d[3]);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_tail: got %b required 0", out_valid);
    end
  endtask

  task automatic test_write_then_read();
    do_reset();
    in_valid = 1'b1; rw = 1'b1; addr = 23'd7; data_in = 32'h12345678;
    tick();
    rw = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || data_out !== 32'h12345678) begin
      bad++; $display("FAIL wr_then_rd: got v=%b %h required v=1 12345678", out_valid, data_out);
    end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    int lat;
    do_reset();
    wr(23'h400, 32'h00000001);
    rd(23'h000, d, lat);
    total++;
    if (lat !== 2 || d !== 32'h00000001) begin
      bad++; $display("FAIL alias_400: got lat=%0d %h required lat=2 00000001", lat, d);
    end
    wr(23'h7FFC0A, 32'hA5A5A5A5);
    rd(23'h00A, d, lat);
    total++;
    if (lat !== 2 || d !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL alias_top: got lat=%0d %h required lat=2 a5a5a5a5", lat, d);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    int lat;
    int seen;
    do_reset();
    wr(23'd9, 32'hCAFE0009);
    in_valid = 1'b1; rw = 1'b0; addr = 23'd9;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    seen = 0;
    tick();
    if (out_valid) seen++;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrst_busy: got %b required 1", busy);
    end
    tick();
    if (out_valid) seen++;
    rst = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrst_busy_release: got %b required 1", busy);
    end
    // Write presented during the INIT cycle must be dropped.
    in_valid = 1'b1; rw = 1'b1; addr = 23'd9; data_in = 32'h00000BAD;
    tick();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL midrst_busy_after: got %b required 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midrst_no_valid: got %0d pulses required 0", seen);
    end
    rd(23'd9, d, lat);
    total++;
    if (lat !== 2 || d !== 32'hCAFE0009) begin
      bad++; $display("FAIL init_drop: got lat=%0d %h required lat=2 cafe0009", lat, d);
    end
  endtask

`ifdef SDRAM_MODEL_REFRESH_STALL_EN
  task automatic test_refresh();
    bit          acc [40];
    bit          exp_busy;
    logic [31:0] d;
    logic [31:0] exp_v;
    int          lat;
    for (int c = 0; c < 40; c++) wr(23'(32'h100 + c), 32'h0);
    do_reset();
    // READY lasts 16 cycles, then 4 stall cycles: period 20 from READY entry.
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; rw = 1'b1;
      addr     = 23'(32'h100 + c);
      data_in  = 32'hAAAA0000 + 32'h100 + c;
      exp_busy = (c % 20) >= 16;
      acc[c]   = !exp_busy;
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL refresh_busy c=%0d: got %b required %b", c, busy, exp_busy);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      exp_v = acc[c] ? (32'hAAAA0000 + 32'h100 + c) : 32'h0;
      rd(23'(32'h100 + c), d, lat);
      total++;
      if (lat !== 2 || d !== exp_v) begin
        bad++; $display("FAIL refresh_readback c=%0d: got lat=%0d %h required lat=2 %h", c, lat, d, exp_v);
      end
    end
    // Reads accepted in cycles 14 and 15 return while busy is high.
    do_reset();
    for (int c = 0; c < 14; c++) tick();
    in_valid = 1'b1; rw = 1'b0; addr = 23'h101;
    tick();
    addr = 23'h102;
    tick();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || data_out !== 32'hAAAA0101) begin
      bad++; $display("FAIL refresh_inflight0: got b=%b v=%b %h required b=1 v=1 aaaa0101", busy, out_valid, data_out);
    end
    tick();
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || data_out !== 32'hAAAA0102) begin
      bad++; $display("FAIL refresh_inflight1: got b=%b v=%b %h required b=1 v=1 aaaa0102", busy, out_valid, data_out);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_rw();
    test_back_to_back();
    test_write_then_read();
    test_alias();
    test_reset_mid_read();
`ifdef SDRAM_MODEL_REFRESH_STALL_EN
    test_refresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sdram_model_resp
`default_nettype wire

// File: doc/sdram_model_resp.md
# sdram_model_resp

Responder for the 32-bit word request interface that the RAM test initiator drives: it accepts read/write requests under a `busy` handshake and returns read data with a fixed `out_valid` latency. It stores data in on-chip block RAM. It stands in for the SDRAM controller in simulation and in on-board loopback builds, so the initiator can be exercised without external memory. An optional mode emulates SDRAM refresh stalls.

## Interface
Parameters:
- `ADDR_W`, 10: stored address bits; the upper `addr` bits are ignored, so the memory aliases.
- `RD_LAT`, 2: cycles from read accept to `out_valid`; minimum 1.
- `REFRESH_PERIOD`, 780: cycles between refresh windows, counted from the end of the previous window.
- `REFRESH_CYCLES`, 8: length of each refresh window.

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  23  word address.
- `rw`  in  1  1 = write, 0 = read.
- `data_in`  in  32  write data.
- `in_valid`  in  1  request strobe.
- `busy`  out  1  registered; when high, requests are not accepted.
- `data_out`  out  32  read data; registered.
- `out_valid`  out  1  one-cycle pulse per read, registered.

## Operation
- A request is accepted on a rising edge where `in_valid && !busy`. Only one request can be accepted per cycle.
- `in_valid` while `busy` is high is dropped: no write, no read, no `out_valid`. The initiator must re-present the request.
- Write: `mem[addr[ADDR_W-1:0]] <= data_in` at the accept edge. No response is produced.
- Read: pushed into an `RD_LAT`-deep valid/data pipeline.
  - Returns are in order; back-to-back reads give back-to-back `out_valid`.
  - A read issued the cycle after a write to the same index returns the new data.
- State machine, encoded in 2 bits:
  - INIT: `busy` = 1. Always moves to READY one cycle after reset release.
  - READY: `busy` = 0. Moves to REFRESH when the refresh counter reaches `REFRESH_PERIOD-1`; only when the macro is enabled.
  - REFRESH: `busy` = 1 for exactly `REFRESH_CYCLES` cycles, then returns to READY. The counter restarts at 0.
  - Any undefined state code goes to INIT.
- Reads already in the pipeline always complete during REFRESH.
- Reset values:
  - `busy` = 1, state = INIT.
  - `out_valid` = 0, `data_out` = 0.
  - Read pipeline cleared and refresh counter = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation: in-flight reads are discarded, with no `out_valid` during or after reset.
- Address wrap: an address of `2^ADDR_W` aliases to index 0. The full 23-bit sweep wraps over the array `2^(23-ADDR_W)` times.

## Timing
- Read accepted at edge N: `out_valid` = 1 and `data_out` valid in the cycle after edge N+`RD_LAT`-1.
  - With `RD_LAT` = 1, data is present in the cycle immediately after the accept edge.
- `busy` changes only on clock edges, so the initiator may sample it combinationally in the same cycle.
- The refresh decision is registered: `busy` rises in the cycle after the counter reaches `REFRESH_PERIOD-1`. A request presented in that counter-terminal cycle is still accepted.
- Sustained throughput is one request per cycle outside refresh windows.

## Configuration
- Macro: `SDRAM_MODEL_REFRESH_STALL_EN`.
- Defined: the refresh counter and REFRESH state are present, and `busy` follows the pattern above.
- Undefined: no counter is built and REFRESH is unreachable. `busy` is high only in INIT (reset plus one cycle) and 0 otherwise.

## Structure
- Shared package `sdram_if_pkg`:
  - Interface widths: `ADDR_BITS` = 23, `DATA_BITS` = 32.
  - State encodings: INIT = 0, READY = 1, REFRESH = 2.
  - The initiator uses the same package.
- Sub-module `bram_sp`:
  - Single-port, synchronous write.
  - Write-first for a read on the following cycle.
  - Parameterised depth `2^ADDR_W`, width 32.
- The read pipeline, FSM and counter live in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5, then read addr 5 -> single `out_valid` exactly `RD_LAT` cycles after the read accept, with `data_out` = 0xDEADBEEF.
- Write 0x11111111, 0x22222222, 0x33333333, 0x44444444 to addrs 0–3, then issue 4 back-to-back reads -> 4 consecutive `out_valid` cycles returning the values in order.
- `ADDR_W` = 10: write 0x00000001 to addr 0x400, then read addr 0 -> 0x00000001.
- Macro defined, `REFRESH_PERIOD` = 16, `REFRESH_CYCLES` = 4, `in_valid` held with writes of 0xAAAA0000+addr -> `busy` high for exactly 4 cycles every 20 cycles. Writes presented while busy are absent on readback, and reads in flight at refresh entry still return data.
- Issue a read, assert `rst` on the next cycle -> no `out_valid`. `busy` = 1 during reset and for one cycle after release, then 0.
- Write 0x12345678 to addr 7 at edge N and read addr 7 at edge N+1 -> returns 0x12345678.
